// File: rtl/aes_ctrl_seq.sv
// rtl/aes_ctrl_seq.sv - byte-serial AES-128 control sequencer (LOAD, 10 rounds, OUT).
// Build option AES_CTRL_DUMMY_MC_EN: round 9 runs a full 20 cycles with held MixColumns strobes.
module aes_ctrl_seq (
  input  logic       ClkxCI,
  input  logic       RstxRI,
  input  logic       StartxSI,
  output logic       BusyxSO,
  output logic       LoadxSO,
  output logic       ShiftRowsxSO,
  output logic       MixColumnsxSO,
  output logic       NineRoundxSO,
  output logic [7:0] RconxDO,
  output logic       OutValidxSO,
  output logic       DonexSO
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_OUT} state_t;

`ifdef AES_CTRL_DUMMY_MC_EN
  localparam logic [4:0] LAST_CYC_R9 = 5'd19;
`else
  localparam logic [4:0] LAST_CYC_R9 = 5'd15;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cyc;
  logic [4:0]  w_cyc_nxt;
  logic [3:0]  r_rnd;
  logic [3:0]  w_rnd_nxt;
  logic [7:0]  r_rcon;
  logic [7:0]  w_rcon_nxt;
  logic        w_rnd_end;
  logic [7:0]  w_xtime;

  assign w_rnd_end = (r_rnd == 4'd9) ? (r_cyc == LAST_CYC_R9) : (r_cyc == 5'd19);
  assign w_xtime   = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_state <= S_IDLE;
      r_cyc   <= 5'd0;
      r_rnd   <= 4'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_rnd   <= w_rnd_nxt;
      r_rcon  <= w_rcon_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc + 5'd1;
    w_rnd_nxt   = r_rnd;
    w_rcon_nxt  = r_rcon;
    case (r_state)
      S_IDLE: begin
        w_cyc_nxt = 5'd0;
        if (StartxSI) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (r_cyc == 5'd15) begin
          w_state_nxt = S_ROUND;
          w_cyc_nxt   = 5'd0;
          w_rnd_nxt   = 4'd0;
          w_rcon_nxt  = 8'h01;
        end
      end
      S_ROUND: begin
        if (w_rnd_end) begin
          w_cyc_nxt = 5'd0;
          if (r_rnd == 4'd9) begin
            w_state_nxt = S_OUT;
          end else begin
            w_rnd_nxt  = r_rnd + 4'd1;
            w_rcon_nxt = w_xtime;
          end
        end
      end
      S_OUT: begin
        // A start held high chains straight into the next LOAD with no IDLE gap.
        if (r_cyc == 5'd15) begin
          w_cyc_nxt   = 5'd0;
          w_state_nxt = StartxSI ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = 5'd0;
      end
    endcase
  end

  always_comb begin
    BusyxSO       = (r_state != S_IDLE);
    LoadxSO       = (r_state == S_LOAD);
    ShiftRowsxSO  = (r_state == S_ROUND) && (r_cyc == 5'd15);
    MixColumnsxSO = (r_state == S_ROUND) && (r_cyc >= 5'd16);
    NineRoundxSO  = (r_state == S_ROUND) && (r_rnd == 4'd9);
    RconxDO       = r_rcon;
    OutValidxSO   = (r_state == S_OUT);
    DonexSO       = (r_state == S_OUT) && (r_cyc == 5'd15);
  end

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// tb/tb_aes_ctrl_seq.sv - scoreboard bench for aes_ctrl_seq against a cycle-index timeline model.
module tb_aes_ctrl_seq;

`ifdef AES_CTRL_DUMMY_MC_EN
  localparam int ROUND_SPAN = 200;
`else
  localparam int ROUND_SPAN = 196;
`endif
  localparam int OUT_START = 16 + ROUND_SPAN;
  localparam int LAT       = OUT_START + 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, load, sr, mc, nine, ov, done;
  logic [7:0] rcon;

  always #5 clk = ~clk;

  aes_ctrl_seq dut (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .BusyxSO(busy), .LoadxSO(load),
    .ShiftRowsxSO(sr), .MixColumnsxSO(mc), .NineRoundxSO(nine), .RconxDO(rcon),
    .OutValidxSO(ov), .DonexSO(done)
  );

  typedef struct packed {
    logic busy, load, sr, mc, nine, ov, done, rcon_chk;
    logic [7:0] rcon;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         t = -1;
  bit         idle_rcon_known = 1'b0;
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  // Expected outputs for cycle tt of a run (tt < 0 means idle).
  function automatic exp_t model_out(input int tt);
    exp_t e;
    int   r, c;
    e = '0;
    if (tt < 0) begin
      e.rcon_chk = idle_rcon_known;
      e.rcon     = 8'h01;
      return e;
    end
    e.busy = 1'b1;
    if (tt < 16) begin
      e.load = 1'b1;
    end else if (tt < OUT_START) begin
      r = (tt - 16) / 20;
      c = (tt - 16) % 20;
      e.sr       = (c == 15);
      e.mc       = (c >= 16);
      e.nine     = (r == 9);
      e.rcon     = rcon_tab[r];
      e.rcon_chk = 1'b1;
    end else begin
      e.ov   = 1'b1;
      e.done = (tt == LAT - 1);
    end
    return e;
  endfunction

  task automatic step(input bit s, input bit r);
    start = s;
    rst   = r;
    @(posedge clk);
    #1;
    if (r) begin
      t = -1;
      idle_rcon_known = 1'b1;
    end else if (t < 0) begin
      if (s) t = 0;
    end else if (t == LAT - 1) begin
      t = s ? 0 : -1;
      idle_rcon_known = 1'b0;
    end else begin
      t++;
    end
    q.push_back(model_out(t));
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("busy", busy, e.busy);
      chk("load", load, e.load);
      chk("shiftrows", sr, e.sr);
      chk("mixcolumns", mc, e.mc);
      chk("nineround", nine, e.nine);
      chk("outvalid", ov, e.ov);
      chk("done", done, e.done);
      if (e.rcon_chk) chk("rcon", rcon, e.rcon);
      chk("exclusive", int'($countones({load, sr, mc, ov}) <= 1), 1);
    end
  end

  initial begin
    step(0, 1);
    step(0, 1);
    repeat (5) step(0, 0);
    // Single pulse, then random start noise while busy.
    step(1, 0);
    for (int i = 0; i < LAT + 6; i++)
      step((t >= 0 && t < LAT - 1) ? bit'($urandom % 2) : 1'b0, 0);
    // Start held high: back-to-back runs.
    for (int i = 0; i < 2 * LAT + 4; i++) step(1, 0);
    for (int i = 0; i < LAT + 5; i++) step(0, 0);
    // Reset in the middle of round 4, then a clean run.
    step(1, 0);
    for (int i = 0; i < 200 && t < 100; i++) step(0, 0);
    step(0, 1);
    repeat (3) step(0, 0);
    step(1, 0);
    for (int i = 0; i < LAT + 3; i++) step(0, 0);
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
